// File: rtl/wb_pkg.sv
// Shared widths and the completion record used by the writeback commit unit.
// One record type serves the ALU/LSU requests, the buffer entries and the write port.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency completion buffer: registered head, no fall-through.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    wb_req_t       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign head    = mem[rptr[IW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: arbitrates ALU and buffered long-latency completions onto
// the single register-file write port and keeps the busy scoreboard for issue stalls.
module wb_commit_unit #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [AW-1:0]     iss_rs1,
    input  logic [AW-1:0]     iss_rs2,
    input  logic              iss_rs1_en,
    input  logic              iss_rs2_en,
    output logic              iss_stall,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [AW-1:0]     lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [XLEN-1:0]   wr_data,
    output logic [2**AW-1:0]  busy,
    output logic              err
);

    import wb_pkg::wb_req_t;

    localparam int NREG = 2 ** AW;

    wb_req_t   alu_req;
    wb_req_t   lsu_req;
    wb_req_t   head;
    wb_req_t   win;
    wb_req_t   wr_q;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      win_valid;
    logic      commit;
    logic      issue;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign lsu_req = '{rd: lsu_rd, data: lsu_data};

    // Handshake: a completion transfers on a cycle where valid && ready at the edge;
    // ready depends only on buffer fullness and reset, never on valid.
    assign alu_ready = rst_n && !full;
    assign lsu_ready = rst_n && !full;
    assign push      = lsu_valid && lsu_ready;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (lsu_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A full buffer preempts the ALU so the oldest long-latency result cannot starve.
    always_comb begin
        win_valid = 1'b0;
        win       = alu_req;
        pop       = 1'b0;
        if (rst_n) begin
            if (full) begin
                win_valid = 1'b1;
                win       = head;
                pop       = 1'b1;
            end else if (alu_valid) begin
                win_valid = 1'b1;
            end else if (!empty) begin
                win_valid = 1'b1;
                win       = head;
                pop       = 1'b1;
            end
        end
    end

    assign commit = win_valid && (win.rd != '0);

    // No bypass from the clear in flight: a pending write still stalls its readers.
    assign iss_stall = iss_valid && ((iss_rs1_en && busy_q[iss_rs1]) ||
                                     (iss_rs2_en && busy_q[iss_rs2]) ||
                                     busy_q[iss_rd]);
    assign issue     = iss_valid && !iss_stall && (iss_rd != '0);

    always_comb begin
        busy_next = busy_q;
        if (wr_en) begin
            busy_next[wr_q.rd] = 1'b0;
        end
        if (issue) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            wr_en  <= 1'b0;
            wr_q   <= '0;
            err    <= 1'b0;
        end else begin
            busy_q <= busy_next;
            wr_en  <= commit;
            if (commit) begin
                wr_q <= win;
            end
            if (commit && !busy_q[win.rd]) begin
                err <= 1'b1;
            end
        end
    end

    assign wr_addr = wr_q.rd;
    assign wr_data = wr_q.data;
    assign busy    = busy_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed vector table, hand-written corner sequences and
// random traffic checked every cycle against a queue-based reference model.
module tb_wb_commit_unit;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic [AW-1:0]     iss_rs1;
  logic [AW-1:0]     iss_rs2;
  logic              iss_rs1_en;
  logic              iss_rs2_en;
  logic              iss_stall;
  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [AW-1:0]     lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [31:0]       busy;
  logic              err;

  wb_commit_unit #(
    .XLEN       (XLEN),
    .AW         (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rs1_en (iss_rs1_en),
    .iss_rs2_en (iss_rs2_en),
    .iss_stall  (iss_stall),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .err        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: register-level view of the spec, buffer kept as a queue
  logic [31:0]          m_busy;
  logic [AW+XLEN-1:0]   exp_q[$];
  logic                 m_wr_en;
  logic [AW-1:0]        m_wr_addr;
  logic [XLEN-1:0]      m_wr_data;
  logic                 m_err;

  task automatic model_reset();
    m_busy    = '0;
    exp_q.delete();
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_err     = 1'b0;
  endtask

  function automatic logic model_stall();
    return iss_valid && ((iss_rs1_en && m_busy[iss_rs1]) ||
                         (iss_rs2_en && m_busy[iss_rs2]) || m_busy[iss_rd]);
  endfunction

  task automatic check_model();
    logic full;
    full = (exp_q.size() == DEPTH);
    chk("m_stall", iss_stall, model_stall());
    chk("m_alu_ready", alu_ready, rst_n && !full);
    chk("m_lsu_ready", lsu_ready, rst_n && !full);
    chk("m_wr_en", wr_en, m_wr_en);
    chk("m_wr_addr", wr_addr, m_wr_addr);
    chk("m_wr_data", wr_data, m_wr_data);
    chk("m_busy", busy, m_busy);
    chk("m_err", err, m_err);
  endtask

  task automatic step_model();
    logic               full;
    logic               have;
    logic [AW+XLEN-1:0] w;
    logic [31:0]        nb;
    if (!rst_n) begin
      model_reset();
    end else begin
      full = (exp_q.size() == DEPTH);
      have = 1'b0;
      w    = '0;
      nb   = m_busy;
      if (m_wr_en) nb[m_wr_addr] = 1'b0;
      if (iss_valid && !model_stall() && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (full) begin
        w = exp_q.pop_front();
        have = 1'b1;
      end else if (alu_valid) begin
        w = {alu_rd, alu_data};
        have = 1'b1;
      end else if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        have = 1'b1;
      end
      if (lsu_valid && !full) exp_q.push_back({lsu_rd, lsu_data});
      if (have && w[AW+XLEN-1:XLEN] != 0) begin
        if (!m_busy[w[AW+XLEN-1:XLEN]]) m_err = 1'b1;
        m_wr_en   = 1'b1;
        m_wr_addr = w[AW+XLEN-1:XLEN];
        m_wr_data = w[XLEN-1:0];
      end else begin
        m_wr_en = 1'b0;
      end
      m_busy = nb;
    end
  endtask

  // driver tasks
  task automatic set_idle();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rs1_en = 0; iss_rs2_en = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    step_model();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  irs1;
    logic        irs1_en;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_stall;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_wr_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[16];

  logic [AW-1:0]   got_q[$];
  logic [AW-1:0]   exp_order[15];
  logic [AW-1:0]   inflight[$];
  logic            a_pend, l_pend;
  logic [AW-1:0]   a_rd, l_rd;
  logic [XLEN-1:0] a_d, l_d;

  initial begin
    //              iv ird rs1 en  av ard ad            lv lrd ld      stl ar lr we addr data          busy        err
    tbl[0]  = '{1, 5, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 0, 0,            32'h0,      0};
    tbl[1]  = '{1, 6, 5, 1,  0, 0, 0,            0, 0, 0,     1, 1, 1, 0, 0, 0,            32'h20,     0};
    tbl[2]  = '{1, 6, 5, 1,  1, 5, 32'hDEADBEEF, 0, 0, 0,     1, 1, 1, 0, 0, 0,            32'h20,     0};
    tbl[3]  = '{1, 6, 5, 1,  0, 0, 0,            0, 0, 0,     1, 1, 1, 1, 5, 32'hDEADBEEF, 32'h20,     0};
    tbl[4]  = '{1, 6, 5, 1,  0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 5, 32'hDEADBEEF, 32'h0,      0};
    tbl[5]  = '{1, 3, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 5, 32'hDEADBEEF, 32'h40,     0};
    tbl[6]  = '{1, 7, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 5, 32'hDEADBEEF, 32'h48,     0};
    tbl[7]  = '{0, 0, 0, 0,  1, 3, 32'h33,       1, 7, 32'h77, 0, 1, 1, 0, 5, 32'hDEADBEEF, 32'hC8,     0};
    tbl[8]  = '{0, 0, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 3, 32'h33,       32'hC8,     0};
    tbl[9]  = '{0, 0, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 7, 32'h77,       32'hC0,     0};
    tbl[10] = '{1, 6, 0, 0,  0, 0, 0,            0, 0, 0,     1, 1, 1, 0, 7, 32'h77,       32'h40,     0};
    tbl[11] = '{0, 0, 0, 0,  1, 0, 32'h1234,     0, 0, 0,     0, 1, 1, 0, 7, 32'h77,       32'h40,     0};
    tbl[12] = '{0, 0, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 7, 32'h77,       32'h40,     0};
    tbl[13] = '{0, 0, 0, 0,  1, 9, 32'h99,       0, 0, 0,     0, 1, 1, 0, 7, 32'h77,       32'h40,     0};
    tbl[14] = '{0, 0, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 1, 9, 32'h99,       32'h40,     1};
    tbl[15] = '{0, 0, 0, 0,  0, 0, 0,            0, 0, 0,     0, 1, 1, 0, 9, 32'h99,       32'h40,     1};

    exp_order = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd8, 5'd20, 5'd9, 5'd21,
                  5'd22, 5'd23, 5'd24, 5'd25, 5'd10, 5'd11, 5'd12};

    // power-up reset
    set_idle();
    rst_n = 1'b0;
    model_reset();
    next();
    next();

    // reset with traffic present
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h5; iss_valid = 1; iss_rd = 5'd4;
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    next();
    set_idle();
    rst_n = 1'b1;
    tick();
    chk("post_rst_lsu_ready", lsu_ready, 1);
    next();

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; iss_rs1 = tbl[i].irs1;
      iss_rs1_en = tbl[i].irs1_en; iss_rs2 = 0; iss_rs2_en = 0;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      tick();
      chk($sformatf("t%0d_stall", i), iss_stall, tbl[i].e_stall);
      chk($sformatf("t%0d_alu_ready", i), alu_ready, tbl[i].e_ardy);
      chk($sformatf("t%0d_lsu_ready", i), lsu_ready, tbl[i].e_lrdy);
      chk($sformatf("t%0d_wr_en", i), wr_en, tbl[i].e_wr_en);
      chk($sformatf("t%0d_wr_addr", i), wr_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_wr_data", i), wr_data, tbl[i].e_data);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("t%0d_err", i), err, tbl[i].e_err);
      next();
    end

    // reset mid-operation (busy[6] pending, err set)
    set_idle();
    rst_n = 1'b0;
    lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 32'h66;
    tick();
    next();
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    next();
    set_idle();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_wr_en", wr_en, 0);
    next();

    // buffer fill against continuous ALU traffic
    for (int i = 0; i < 15; i++) begin
      iss_valid = 1;
      iss_rd = (i < 5) ? AW'(8 + i) : AW'(16 + i - 5);
      tick();
      next();
    end
    set_idle();
    begin
      int ai = 0;
      int li = 0;
      got_q.delete();
      for (int k = 0; k < 40; k++) begin
        alu_valid = (ai < 10); alu_rd = AW'(16 + ai); alu_data = 32'hA000 + ai;
        lsu_valid = (li < 5);  lsu_rd = AW'(8 + li);  lsu_data = 32'hB000 + li;
        tick();
        if (wr_en) got_q.push_back(wr_addr);
        if (k == 4) begin
          chk("full_lsu_ready", lsu_ready, 0);
          chk("full_alu_ready", alu_ready, 0);
        end
        if (alu_valid && alu_ready) ai++;
        if (lsu_valid && lsu_ready) li++;
        next();
      end
      set_idle();
      chk("full_write_count", got_q.size(), 15);
      for (int i = 0; i < 15; i++) begin
        chk($sformatf("full_order%0d", i), (i < got_q.size()) ? got_q[i] : 5'h1f, exp_order[i]);
      end
      chk("full_err", err, 0);
    end

    // random traffic
    a_pend = 0; l_pend = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
    inflight.delete();
    for (int c = 0; c < 1500; c++) begin
      rst_n = !(c >= 700 && c < 702);
      if (!rst_n) begin
        inflight.delete();
        a_pend = 0;
        l_pend = 0;
      end
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_d = $urandom();
        if (inflight.size() > 0) begin
          int idx = $urandom_range(0, inflight.size() - 1);
          a_rd = inflight[idx];
          inflight.delete(idx);
          a_pend = 1;
        end else if ($urandom_range(0, 7) == 0) begin
          a_rd = 0;
          a_pend = 1;
        end
      end
      if (!l_pend && $urandom_range(0, 1) == 0) begin
        l_d = $urandom();
        if (inflight.size() > 0) begin
          int idx = $urandom_range(0, inflight.size() - 1);
          l_rd = inflight[idx];
          inflight.delete(idx);
          l_pend = 1;
        end
      end
      alu_valid = a_pend; alu_rd = a_rd; alu_data = a_d;
      lsu_valid = l_pend; lsu_rd = l_rd; lsu_data = l_d;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = AW'($urandom_range(0, 31));
      iss_rs1 = AW'($urandom_range(0, 31));
      iss_rs2 = AW'($urandom_range(0, 31));
      iss_rs1_en = 1'($urandom_range(0, 1));
      iss_rs2_en = 1'($urandom_range(0, 1));
      tick();
      if (rst_n) begin
        if (alu_valid && alu_ready) a_pend = 0;
        if (lsu_valid && lsu_ready) l_pend = 0;
        if (iss_valid && !iss_stall && iss_rd != 0) inflight.push_back(iss_rd);
      end
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
